inst_fetch: RTL and testbench

- Front-end fetch stage that sits directly upstream of the instruction queue.
- Owns the architectural fetch PC and issues in-order requests to InstCache.
- Pairs each returned instruction with its PC and writes the pair into the instruction queue.
- Handles redirects from branch resolution/flush by discarding in-flight stale responses; throttles on instruction-queue credit so the queue never overflows.

---
 rtl/inst_fetch_pkg.sv | 17 +
 rtl/fetch_pc_fifo.sv | 65 ++++++
 rtl/inst_fetch.sv | 122 ++++++++++++
 tb/tb_inst_fetch.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/inst_fetch_pkg.sv
// Shared constants and helpers for the fetch front end.
package inst_fetch_pkg;

  localparam int unsigned InstAddrWidth  = 32;
  localparam int unsigned InstWidth      = 32;
  localparam int unsigned MaxOutstanding = 2;
  localparam int unsigned IqCntWidth     = 5;

  localparam logic [InstAddrWidth-1:0] ResetPc = '0;
  localparam logic [InstAddrWidth-1:0] PcIncr  = 32'd4;

  // Bits needed to hold the values 0..max_val (at least 1).
  function automatic int unsigned cnt_width(int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/fetch_pc_fifo.sv
// Small synchronous FIFO holding the PCs of requests still in flight at the cache.
module fetch_pc_fifo
  import inst_fetch_pkg::*;
#(
  parameter int unsigned Depth = 2,
  parameter int unsigned Width = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = cnt_width(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             do_push, do_pop;

  // Explicit wrap so a non-power-of-two depth (or depth 1) still works.
  function automatic logic [PtrW-1:0] ptr_inc(logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CntW'(Depth));
  assign rdata_o = mem_q[rd_ptr_q];

  // Push while full is only allowed when a pop frees the slot in the same cycle.
  always_comb begin
    do_push  = push_i && (!full_o || pop_i);
    do_pop   = pop_i && !empty_o;
    wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = do_pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    cnt_d    = cnt_q + CntW'(do_push) - CntW'(do_pop);
  end

  // Pointer and occupancy state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/inst_fetch.sv
// Fetch stage: owns the fetch PC, issues in-order cache requests, pairs responses
// with their PCs and writes them to the instruction queue, dropping stale responses
// after a redirect.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter int unsigned      ADDR_W   = InstAddrWidth,
  parameter int unsigned      INST_W   = InstWidth,
  parameter int unsigned      MAX_OUT  = MaxOutstanding,
  parameter int unsigned      CNT_W    = IqCntWidth,
  parameter logic [ADDR_W-1:0] RESET_PC = ResetPc
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              redirect_valid_i,
  input  logic [ADDR_W-1:0] redirect_pc_i,
  output logic              icache_req_valid_o,
  output logic [ADDR_W-1:0] icache_req_addr_o,
  input  logic              icache_req_ready_i,
  input  logic              icache_resp_valid_i,
  input  logic [INST_W-1:0] icache_resp_inst_i,
  input  logic [CNT_W-1:0]  iq_free_i,
  output logic              iq_write_o,
  output logic [INST_W-1:0] iq_inst_o,
  output logic [ADDR_W-1:0] iq_pc_o
);

  localparam int unsigned OutW  = cnt_width(MAX_OUT);
  localparam int unsigned GateW = CNT_W + 1;

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [OutW-1:0]   out_q, out_d;
  logic [OutW-1:0]   discard_q, discard_d;
  logic              iq_write_q, iq_write_d;
  logic [INST_W-1:0] iq_inst_q, iq_inst_d;
  logic [ADDR_W-1:0] iq_pc_q, iq_pc_d;

  logic              fire;
  logic              resp_ok;
  logic [ADDR_W-1:0] fifo_pc;
  logic              fifo_empty, fifo_full;

  // FIFO occupancy tracks out_q exactly; its empty flag screens out responses
  // that arrive with nothing outstanding.
  fetch_pc_fifo #(
    .Depth (MAX_OUT),
    .Width (ADDR_W)
  ) u_pc_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (fire),
    .wdata_i (pc_q),
    .pop_i   (resp_ok),
    .rdata_o (fifo_pc),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  // Issue gate: the in-flight writes plus outstanding requests must fit in the
  // queue's free space so the queue can never overflow.
  always_comb begin
    icache_req_valid_o = rst_ni && !redirect_valid_i && !fifo_full &&
                         (out_q < OutW'(MAX_OUT)) &&
                         ((GateW'(out_q) + GateW'(iq_write_q)) < GateW'(iq_free_i));
    fire    = icache_req_valid_o && icache_req_ready_i;
    resp_ok = icache_resp_valid_i && !fifo_empty;
  end

  // Next-state for PC, counters and the queue write port.
  always_comb begin
    pc_d       = pc_q;
    out_d      = out_q + OutW'(fire) - OutW'(resp_ok);
    discard_d  = discard_q;
    iq_write_d = 1'b0;
    iq_inst_d  = iq_inst_q;
    iq_pc_d    = iq_pc_q;

    if (redirect_valid_i) begin
      // Everything still in flight after this cycle is stale.
      pc_d      = redirect_pc_i;
      discard_d = out_d;
    end else begin
      if (fire) begin
        pc_d = pc_q + ADDR_W'(PcIncr);
      end
      if (resp_ok) begin
        if (discard_q != '0) begin
          discard_d = discard_q - OutW'(1);
        end else begin
          iq_write_d = 1'b1;
          iq_inst_d  = icache_resp_inst_i;
          iq_pc_d    = fifo_pc;
        end
      end
    end
  end

  // Architectural state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pc_q       <= RESET_PC;
      out_q      <= '0;
      discard_q  <= '0;
      iq_write_q <= 1'b0;
      iq_inst_q  <= '0;
      iq_pc_q    <= '0;
    end else begin
      pc_q       <= pc_d;
      out_q      <= out_d;
      discard_q  <= discard_d;
      iq_write_q <= iq_write_d;
      iq_inst_q  <= iq_inst_d;
      iq_pc_q    <= iq_pc_d;
    end
  end

  assign icache_req_addr_o = pc_q;
  assign iq_write_o        = iq_write_q;
  assign iq_inst_o         = iq_inst_q;
  assign iq_pc_o           = iq_pc_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Randomised scoreboard bench for inst_fetch with a request-list reference model.
module tb_inst_fetch;
  import inst_fetch_pkg::*;

  localparam int unsigned MO  = 2;
  localparam logic [31:0] RPC = 32'h0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        icache_req_valid;
  logic [31:0] icache_req_addr;
  logic        icache_req_ready;
  logic        icache_resp_valid;
  logic [31:0] icache_resp_inst;
  logic [4:0]  iq_free;
  logic        iq_write;
  logic [31:0] iq_inst;
  logic [31:0] iq_pc;

  inst_fetch #(
    .ADDR_W   (32),
    .INST_W   (32),
    .MAX_OUT  (MO),
    .CNT_W    (5),
    .RESET_PC (RPC)
  ) dut (
    .clk_i               (clk),
    .rst_ni              (rst_n),
    .redirect_valid_i    (redirect_valid),
    .redirect_pc_i       (redirect_pc),
    .icache_req_valid_o  (icache_req_valid),
    .icache_req_addr_o   (icache_req_addr),
    .icache_req_ready_i  (icache_req_ready),
    .icache_resp_valid_i (icache_resp_valid),
    .icache_resp_inst_i  (icache_resp_inst),
    .iq_free_i           (iq_free),
    .iq_write_o          (iq_write),
    .iq_inst_o           (iq_inst),
    .iq_pc_o             (iq_pc)
  );

  always #5 clk = ~clk;

  typedef struct {logic [31:0] pc; logic [31:0] inst;} exp_t;
  typedef struct {logic [31:0] pc; bit stale;} pend_t;
  typedef struct {logic [31:0] addr; logic [31:0] inst; int due;} creq_t;

  exp_t  exp_q[$];    // expected queue writes, consumed by the monitor
  pend_t pend_q[$];   // model: requests accepted but not yet answered
  creq_t cache_q[$];  // cache model: accepted requests awaiting a response

  int checks = 0;
  int errors = 0;
  logic [31:0] m_pc;
  bit wr_now;
  int cyc;
  int free_lo, free_hi, lat_lo, lat_hi, ready_pct, resp_pct, redir_pct;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: every cycle the queue write must match the scoreboard head exactly.
  always @(posedge clk) begin : monitor
    exp_t e;
    bit   exp_w;
    #1;
    if (rst_n) begin
      exp_w = (exp_q.size() != 0);
      check("iq_write", 64'(iq_write), 64'(exp_w));
      if (exp_w) begin
        e = exp_q.pop_front();
        if (iq_write) begin
          check("iq_pc", 64'(iq_pc), 64'(e.pc));
          check("iq_inst", 64'(iq_inst), 64'(e.inst));
        end
      end
    end
  end

  // One cycle of stimulus plus model update; inputs change on the falling edge.
  task automatic step(input bit force_redir, input logic [31:0] force_pc);
    bit          redir, ready, resp, exp_rv, fire_m, fire_d, wr_next;
    logic [31:0] rpc;
    int          free, lat, outs;
    creq_t       c;
    pend_t       p;
    @(negedge clk);
    redir = force_redir || (int'($urandom_range(99)) < redir_pct);
    rpc   = force_redir ? force_pc : ($urandom & 32'hFFFF_FFFC);
    ready = int'($urandom_range(99)) < ready_pct;
    free  = int'($urandom_range(free_hi, free_lo));
    resp  = (cache_q.size() != 0) && (pend_q.size() != 0) && (cache_q[0].due <= cyc) &&
            (int'($urandom_range(99)) < resp_pct);
    redirect_valid    = redir;
    redirect_pc       = rpc;
    icache_req_ready  = ready;
    iq_free           = 5'(free);
    icache_resp_valid = resp;
    icache_resp_inst  = resp ? cache_q[0].inst : $urandom;
    #1;
    outs   = pend_q.size();
    exp_rv = !redir && (outs < int'(MO)) && (outs + int'(wr_now) < free);
    check("req_valid", 64'(icache_req_valid), 64'(exp_rv));
    check("req_addr", 64'(icache_req_addr), 64'(m_pc));
    fire_m  = exp_rv && ready;
    fire_d  = icache_req_valid && ready;
    wr_next = 1'b0;
    if (resp) begin
      c = cache_q.pop_front();
      p = pend_q.pop_front();
      if (!redir && !p.stale) begin
        exp_q.push_back('{pc: p.pc, inst: c.inst});
        wr_next = 1'b1;
      end
    end
    if (redir) begin
      foreach (pend_q[i]) pend_q[i].stale = 1'b1;
      m_pc = rpc;
    end else if (fire_m) begin
      pend_q.push_back('{pc: m_pc, stale: 1'b0});
      m_pc = m_pc + 32'd4;
    end
    if (fire_d) begin
      lat = int'($urandom_range(lat_hi, lat_lo));
      cache_q.push_back('{addr: icache_req_addr, inst: $urandom, due: cyc + lat});
    end
    wr_now = wr_next;
    cyc++;
  endtask

  task automatic idle_inputs();
    redirect_valid    = 1'b0;
    redirect_pc       = '0;
    icache_req_ready  = 1'b0;
    icache_resp_valid = 1'b0;
    icache_resp_inst  = '0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_req_valid"}, 64'(icache_req_valid), 64'(0));
    check({tag, "_req_addr"}, 64'(icache_req_addr), 64'(RPC));
    check({tag, "_iq_write"}, 64'(iq_write), 64'(0));
    check({tag, "_iq_inst"}, 64'(iq_inst), 64'(0));
    check({tag, "_iq_pc"}, 64'(iq_pc), 64'(0));
  endtask

  // Asynchronous reset asserted between clock edges, mid-stream.
  task automatic mid_reset();
    rst_n = 1'b0;
    #1;
    check_reset_values("midrst");
    idle_inputs();
    exp_q.delete();
    pend_q.delete();
    cache_q.delete();
    m_pc   = RPC;
    wr_now = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int n;
    idle_inputs();
    iq_free = 5'd16;
    m_pc    = RPC;
    wr_now  = 1'b0;
    cyc     = 0;
    repeat (3) @(negedge clk);
    check_reset_values("rst");
    rst_n = 1'b1;

    // Streaming: always ready, 1-cycle response, plenty of queue space.
    free_lo = 16; free_hi = 16; lat_lo = 1; lat_hi = 1;
    ready_pct = 100; resp_pct = 100; redir_pct = 0;
    repeat (30) step(1'b0, '0);

    // Cache stalls the request for 5 cycles.
    ready_pct = 0;
    repeat (5) step(1'b0, '0);
    ready_pct = 100;

    // One free queue slot, slow cache.
    free_lo = 1; free_hi = 1; lat_lo = 3; lat_hi = 3;
    repeat (30) step(1'b0, '0);

    // Redirect with two requests outstanding.
    free_lo = 16; free_hi = 16;
    n = 0;
    while (pend_q.size() < 2 && n < 10) begin
      step(1'b0, '0);
      n++;
    end
    check("two_outstanding", 64'(pend_q.size()), 64'(2));
    step(1'b1, 32'h100);
    repeat (20) step(1'b0, '0);

    // Randomised mix with redirects, back-pressure and variable latency.
    free_lo = 0; free_hi = 16; lat_lo = 1; lat_hi = 4;
    ready_pct = 70; resp_pct = 60; redir_pct = 8;
    repeat (2000) step(1'b0, '0);

    // Reset in the middle of traffic, then resume.
    ready_pct = 100; resp_pct = 0; redir_pct = 0; free_lo = 16;
    n = 0;
    while (pend_q.size() < 2 && n < 10) begin
      step(1'b0, '0);
      n++;
    end
    mid_reset();
    ready_pct = 70; resp_pct = 60; redir_pct = 8; free_lo = 0;
    repeat (500) step(1'b0, '0);

    // Drain so every expected write is observed.
    redir_pct = 0; ready_pct = 0; resp_pct = 100;
    repeat (20) step(1'b0, '0);
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
